display_page_scheduler: RTL
===========================

Name: display_page_scheduler

Overview:
- Sequences the front-panel display of the signal generator across NUM_PAGES pages: frequency, amplitude and waveform.
- Auto-advances one page per dwell period.
- Supports manual advance, hold, and a parameter-change override that forces the frequency page.
- Replaces free-running show/hide toggles with one scheduled page selector that feeds the display mux.

Parameters:
- DWELL_CYCLES, 200000000, CLOCK cycles per page dwell (2 s at 100 MHz); must be >= 2.
- NUM_PAGES, 3, number of pages cycled (2..4).
- OVERRIDE_DWELLS, 2, dwell periods the frequency page is forced after param_changed (>= 1).
- BLANK_CYCLES, 5000000, blank duration after a page change (PAGE_BLANK_EN builds only).

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous active-high reset.
- enable  input  1  level; low forces IDLE.
- next_btn  input  1  single-cycle pulse (already debounced/synchronised); manual advance.
- hold  input  1  level; freezes the current page.
- param_changed  input  1  single-cycle pulse; a user edit of any generator parameter.
- page  output  2  current page index: 0 = freq, 1 = amplitude, 2 = waveform, 3 = spare.
- page_strobe  output  1  one-cycle pulse, high in the first cycle page shows a new value.
- show_freq  output  1  high when page == 0.
- dwell_tick  output  1  one-cycle pulse on dwell counter terminal count.
- page_blank  output  1  see Optional Feature; tied 0 when the feature is excluded.

Behaviour:
- Reset values: page = 0, page_strobe = 0, show_freq = 1, dwell_tick = 0, page_blank = 0, state = IDLE, dwell counter = 0, override counter = 0.
- All outputs are registered. Decisions made in cycle N appear in cycle N+1.
- Dwell counter:
  - Width $clog2(DWELL_CYCLES).
  - Counts 0..DWELL_CYCLES-1 and wraps to 0.
  - dwell_tick is high in the cycle after the count equals DWELL_CYCLES-1.
  - Counter is cleared to 0 on any page change and while in IDLE.
- States:
  - IDLE: page held at 0, counter cleared. Leaves to AUTO when enable = 1.
  - AUTO: on terminal count, page <= (page+1) mod NUM_PAGES and a strobe fires.
  - HOLD: entered from AUTO when hold = 1. Counter keeps running, but no terminal-count advance occurs. Returns to AUTO when hold = 0, and the counter restarts at 0.
  - OVERRIDE: entered on param_changed from AUTO, HOLD or OVERRIDE.
    - page <= 0 (a strobe fires only if page was nonzero), counter cleared, override counter <= OVERRIDE_DWELLS.
    - Each terminal count decrements the override counter.
    - On reaching 0: go to HOLD if hold = 1, otherwise AUTO. Page is not advanced on that exit tick.
- Priority per cycle: RESET > enable low (-> IDLE, page <= 0, strobe if page was nonzero) > param_changed > next_btn > hold > terminal count.
- next_btn:
  - Accepted in AUTO and HOLD. Advances the page immediately (mod NUM_PAGES), clears the counter, fires a strobe, and stays in the same state.
  - Ignored in OVERRIDE and IDLE.
- Simultaneous next_btn and terminal count: exactly one advance, not two.
- Wrap: the page after NUM_PAGES-1 is 0. Page values >= NUM_PAGES are never produced.
- Asynchronous RESET mid-dwell or mid-override returns all state to reset values at once. No strobe is issued on reset release.

Optional Feature:
- Macro PAGE_BLANK_EN.
- Defined:
  - page_blank goes high in the same cycle as every page_strobe and stays high for BLANK_CYCLES cycles.
  - A new strobe during blanking restarts the blank count.
  - The dwell counter is unaffected.
- Undefined: the blank counter is not instantiated and page_blank is constant 0.

Decomposition:
- Shared package display_pkg:
  - page index constants PAGE_FREQ = 0, PAGE_AMP = 1, PAGE_WAVE = 2.
  - state enum IDLE/AUTO/HOLD/OVERRIDE.
  - PAGE_W = 2.
- One sub-module, dwell_timer.
  - Ports: CLOCK, RESET, clear, terminal-count output.
  - Parameterised by a cycle count.
  - Instantiated for the dwell counter, and again for the blank counter when PAGE_BLANK_EN is defined.

Test Plan (DWELL_CYCLES = 10, NUM_PAGES = 3, OVERRIDE_DWELLS = 2, BLANK_CYCLES = 3):
- Reset, then enable = 1 for 35 cycles -> page steps 0 -> 1 -> 2 -> 0 every 10 cycles, with one page_strobe per change and show_freq high only on page 0.
- On page 1 at count 4, assert hold for 30 cycles -> page stays 1 with no strobes. Release hold -> page 2 exactly 10 cycles later.
- On page 2, pulse param_changed -> page 0 and a strobe the next cycle. Page stays 0 for 20 cycles (next_btn pulses ignored), then resumes AUTO with page 1 after a further 10 cycles.
- Pulse next_btn in the same cycle as terminal count on page 0 -> page becomes 1 (not 2), a single strobe, and the counter restarts.
- Assert RESET asynchronously mid-override on page 0 with a nonzero counter -> all outputs immediately at reset values. Deassert with enable = 0 -> stays IDLE, no strobe.
- PAGE_BLANK_EN defined: after each strobe, page_blank is high for exactly 3 cycles. A next_btn pulse 1 cycle after a strobe extends blanking to 3 cycles after the second strobe.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the front-panel page scheduler.
// Page indices, FSM state encoding and the page-advance helper live here.
package display_pkg;

  localparam int PAGE_W = 2;

  localparam logic [PAGE_W-1:0] PAGE_FREQ = 2'd0;
  localparam logic [PAGE_W-1:0] PAGE_AMP  = 2'd1;
  localparam logic [PAGE_W-1:0] PAGE_WAVE = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AUTO     = 2'd1,
    HOLD     = 2'd2,
    OVERRIDE = 2'd3
  } state_t;

  // Next page in the rotation; anything at or past the last page wraps to 0.
  function automatic logic [PAGE_W-1:0] page_advance(input logic [PAGE_W-1:0] p,
                                                     input int num_pages);
    if (int'(p) >= num_pages - 1) return '0;
    return p + PAGE_W'(1);
  endfunction

endpackage

// File: rtl/display_page_scheduler_if.sv
// Control/status bundle between the panel logic (master) and the page scheduler (slave).
// Also carries the scheduler's FSM state for observation.
interface display_page_scheduler_if;
  import display_pkg::*;

  // No backpressure anywhere: next_btn and param_changed are one-cycle pulses that
  // the scheduler always consumes; enable and hold are levels; all slave outputs
  // are registered and valid every cycle.
  logic              enable;
  logic              next_btn;
  logic              hold;
  logic              param_changed;
  logic [PAGE_W-1:0] page;
  logic              page_strobe;
  logic              show_freq;
  logic              dwell_tick;
  logic              page_blank;
  state_t            state;

  modport master (
    output enable, next_btn, hold, param_changed,
    input  page, page_strobe, show_freq, dwell_tick, page_blank, state
  );

  modport slave (
    input  enable, next_btn, hold, param_changed,
    output page, page_strobe, show_freq, dwell_tick, page_blank, state
  );
endinterface

// File: rtl/dwell_timer.sv
// Free-running modulo-CYCLES counter with synchronous clear.
// tc is high while the count sits on its last value (CYCLES-1).
module dwell_timer #(
  parameter int CYCLES = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic clear,
  output logic tc
);
  localparam int           W    = $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == LAST);
endmodule

// File: rtl/display_page_scheduler.sv
// Scheduled page selector for the signal-generator display mux.
// Optional post-change blanking is built in when PAGE_BLANK_EN is defined.
module display_page_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES    = 200000000,
  parameter int NUM_PAGES       = 3,
  parameter int OVERRIDE_DWELLS = 2,
  parameter int BLANK_CYCLES    = 5000000
) (
  input logic                     CLOCK,
  input logic                     RESET,
  display_page_scheduler_if.slave sched
);
  localparam int               OVR_W    = $clog2(OVERRIDE_DWELLS + 1);
  localparam logic [OVR_W-1:0] OVR_LOAD = OVR_W'(OVERRIDE_DWELLS);

  state_t            state_q, state_nx;
  logic [PAGE_W-1:0] page_q, page_nx;
  logic [OVR_W-1:0]  ovr_q, ovr_nx;
  logic              strobe_q, show_freq_q, tick_q;
  logic              clear_cnt, tc, page_change;

  dwell_timer #(.CYCLES(DWELL_CYCLES)) u_dwell (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .clear (clear_cnt),
    .tc    (tc)
  );

  // Decision for this cycle, in priority order: enable, param edit, button, hold, tc.
  always_comb begin
    state_nx  = state_q;
    page_nx   = page_q;
    ovr_nx    = ovr_q;
    clear_cnt = 1'b0;
    if (!sched.enable) begin
      state_nx  = IDLE;
      page_nx   = PAGE_FREQ;
      ovr_nx    = '0;
      clear_cnt = 1'b1;
    end else if (state_q == IDLE) begin
      state_nx  = AUTO;
      clear_cnt = 1'b1;
    end else if (sched.param_changed) begin
      state_nx  = OVERRIDE;
      page_nx   = PAGE_FREQ;
      ovr_nx    = OVR_LOAD;
      clear_cnt = 1'b1;
    end else if (sched.next_btn && state_q != OVERRIDE) begin
      page_nx   = page_advance(page_q, NUM_PAGES);
      clear_cnt = 1'b1;
    end else begin
      case (state_q)
        AUTO: begin
          if (sched.hold) begin
            state_nx = HOLD;
          end else if (tc) begin
            page_nx   = page_advance(page_q, NUM_PAGES);
            clear_cnt = 1'b1;
          end
        end
        HOLD: begin
          if (!sched.hold) begin
            state_nx  = AUTO;
            clear_cnt = 1'b1;
          end
        end
        OVERRIDE: begin
          // Last forced dwell ends without advancing; the page stays on frequency.
          if (tc) begin
            ovr_nx = ovr_q - OVR_W'(1);
            if (ovr_q <= OVR_W'(1)) begin
              ovr_nx   = '0;
              state_nx = sched.hold ? HOLD : AUTO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign page_change = (page_nx != page_q);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      page_q      <= PAGE_FREQ;
      ovr_q       <= '0;
      strobe_q    <= 1'b0;
      show_freq_q <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_nx;
      page_q      <= page_nx;
      ovr_q       <= ovr_nx;
      strobe_q    <= page_change;
      show_freq_q <= (page_nx == PAGE_FREQ);
      tick_q      <= tc;
    end
  end

  assign sched.page        = page_q;
  assign sched.page_strobe = strobe_q;
  assign sched.show_freq   = show_freq_q;
  assign sched.dwell_tick  = tick_q;
  assign sched.state       = state_q;

`ifdef PAGE_BLANK_EN
  logic blank_tc, blank_q;

  // Restarted by every page change, so a new strobe extends an active blank.
  dwell_timer #(.CYCLES(BLANK_CYCLES)) u_blank (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .clear (page_change),
    .tc    (blank_tc)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      blank_q <= 1'b0;
    end else if (page_change) begin
      blank_q <= 1'b1;
    end else if (blank_tc) begin
      blank_q <= 1'b0;
    end
  end

  assign sched.page_blank = blank_q;
`else
  // BLANK_CYCLES is only meaningful in blanking builds; the output is constant 0 here.
  assign sched.page_blank = 1'b0 & (BLANK_CYCLES != 0);
`endif
endmodule
